// File: rtl/nvdla_cdp_pipe_pkg.sv
// nvdla_cdp_pipe_pkg: shared limits, pointer sizing and stall counter width for the CDP elastic pipe.
// NVDLA_CDP_PIPE_STALL_CNT_EN enables the optional stall counter.
package nvdla_cdp_pipe_pkg;

    localparam int DW_MIN    = 1;
    localparam int DW_MAX    = 512;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;
    localparam int STALL_W   = 16;

`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
    localparam bit STALL_CNT_EN = 1'b1;
`else
    localparam bit STALL_CNT_EN = 1'b0;
`endif

    // A one-entry buffer still needs a 1-bit pointer to index storage.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nvdla_cdp_pipe_ctrl.sv
// nvdla_cdp_pipe_ctrl: pointers, entry count, ready/valid generation and optional stall counter.
// NVDLA_CDP_PIPE_STALL_CNT_EN adds the saturating stall_cnt output.
module nvdla_cdp_pipe_ctrl
    import nvdla_cdp_pipe_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int RDY_BYPASS = 0,
    localparam int PW        = ptr_w(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic               out_rdy,
    input  logic               flush,
    output logic               in_rdy,
    output logic               out_vld,
    output logic               push,
    output logic [PW-1:0]      wr_ptr,
    output logic [PW-1:0]      rd_ptr,
    output logic [CW-1:0]      occ
`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam bit            BYP  = (RDY_BYPASS != 0);

    logic pop;

    // With BYP clear the out_rdy term is constant-folded away, so in_rdy stays registered.
    always_comb begin
        out_vld = occ != '0;
        in_rdy  = (occ != FULL) || (BYP && out_rdy);
        push    = in_vld && in_rdy;
        pop     = out_vld && out_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) stall_cnt <= '0;
        else if (out_vld && !out_rdy && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/nvdla_cdp_dp_elastic_pipe.sv
// nvdla_cdp_dp_elastic_pipe: DEPTH-entry elastic FIFO stage with registered outputs and flush.
// NVDLA_CDP_PIPE_STALL_CNT_EN adds the stall_cnt output.
module nvdla_cdp_dp_elastic_pipe
    import nvdla_cdp_pipe_pkg::*;
#(
    parameter int DW         = 15,
    parameter int DEPTH      = 2,
    parameter int RDY_BYPASS = 0
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DW-1:0]                in_pd,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DW-1:0]                out_pd,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]           stall_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);

    if (DW < DW_MIN || DW > DW_MAX) begin : g_dw_chk
        $error("DW out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
        $error("DEPTH out of range");
    end
    if (RDY_BYPASS != 0 && RDY_BYPASS != 1) begin : g_byp_chk
        $error("RDY_BYPASS must be 0 or 1");
    end

    logic [DW-1:0] mem [DEPTH];
    logic          push;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    nvdla_cdp_pipe_ctrl #(
        .DEPTH      (DEPTH),
        .RDY_BYPASS (RDY_BYPASS)
    ) u_ctrl (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .in_vld    (in_vld),
        .out_rdy   (out_rdy),
        .flush     (flush),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .occ       (occ)
`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Storage is deliberately unreset; validity lives entirely in the count.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) mem[wr_ptr] <= in_pd;
    end

    assign out_pd = mem[rd_ptr];

endmodule

// File: tb/tb_nvdla_cdp_dp_elastic_pipe.sv
// tb_nvdla_cdp_dp_elastic_pipe: three configurations (D2/B0, D4/B0, D1/B1) checked against queue models.
module tb_nvdla_cdp_dp_elastic_pipe;

    logic        clk = 1'b0;
    logic [2:0]  rst, in_vld, out_rdy, flush, in_rdy, out_vld;
    logic [14:0] in_pd  [3];
    logic [14:0] out_pd [3];
    logic [3:0]  occ    [3];
`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt [3];
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : c
        localparam int D  = (g == 1) ? 4 : (g == 2) ? 1 : 2;
        localparam int R  = (g == 2) ? 1 : 0;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] o;

        nvdla_cdp_dp_elastic_pipe #(.DW(15), .DEPTH(D), .RDY_BYPASS(R)) dut (
            .nvdla_core_clk (clk),
            .nvdla_core_rst (rst[g]),
            .in_vld         (in_vld[g]),
            .in_rdy         (in_rdy[g]),
            .in_pd          (in_pd[g]),
            .out_vld        (out_vld[g]),
            .out_rdy        (out_rdy[g]),
            .out_pd         (out_pd[g]),
            .flush          (flush[g]),
            .occ            (o)
`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
            ,
            .stall_cnt      (stall_cnt[g])
`endif
        );

        assign occ[g] = 4'(o);

        // Reference: a queue of held payloads; ready means room, or (bypass) the head leaves now.
        logic [14:0] q[$];
        bit live = 1'b0;
        always @(negedge clk) begin
            bit room;
            bit acc;
            room = (q.size() != D) || (R == 1 && out_rdy[g]);
            if (live) begin
                chk(g, "mon_in_rdy", 32'(in_rdy[g]), 32'(room));
                chk(g, "mon_out_vld", 32'(out_vld[g]), 32'(q.size() != 0));
                chk(g, "mon_occ", 32'(occ[g]), q.size());
                if (q.size() != 0) chk(g, "mon_out_pd", 32'(out_pd[g]), 32'(q[0]));
            end
            if (rst[g]) begin
                q.delete();
                live = 1'b1;
            end else if (flush[g]) begin
                q.delete();
            end else begin
                acc = in_vld[g] && room;
                if (q.size() != 0 && out_rdy[g]) void'(q.pop_front());
                if (acc) q.push_back(in_pd[g]);
            end
        end
    end

    initial begin
        rst = 3'b111; in_vld = '0; out_rdy = '0; flush = '0;
        for (int k = 0; k < 3; k++) in_pd[k] = '0;
        step(); step();
        rst = '0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(k, "reset_in_rdy", 32'(in_rdy[k]), 1);
            chk(k, "reset_out_vld", 32'(out_vld[k]), 0);
            chk(k, "reset_occ", 32'(occ[k]), 0);
        end

        // cfg0: two pushes fill the buffer, then drain in order
        step(); in_vld[0] = 1; in_pd[0] = 15'h0001;
        step(); in_pd[0] = 15'h0002;
        step(); in_vld[0] = 0; out_rdy[0] = 1;
        @(negedge clk);
        chk(0, "fill_occ", 32'(occ[0]), 2);
        chk(0, "fill_in_rdy", 32'(in_rdy[0]), 0);
        chk(0, "fill_head", 32'(out_pd[0]), 32'h1);
        step();
        @(negedge clk);
        chk(0, "drain_second", 32'(out_pd[0]), 32'h2);
        chk(0, "drain_in_rdy", 32'(in_rdy[0]), 1);
        step(); out_rdy[0] = 0;
        @(negedge clk);
        chk(0, "drain_empty", 32'(out_vld[0]), 0);

        // cfg0: reset mid-transfer discards held entries
        step(); in_vld[0] = 1; in_pd[0] = 15'h000A;
        step(); in_pd[0] = 15'h000B;
        step(); rst[0] = 1; in_pd[0] = 15'h000C;
        @(negedge clk);
        chk(0, "prerst_occ", 32'(occ[0]), 2);
        step(); rst[0] = 0; in_vld[0] = 0; out_rdy[0] = 1;
        @(negedge clk);
        chk(0, "rst_occ", 32'(occ[0]), 0);
        chk(0, "rst_out_vld", 32'(out_vld[0]), 0);
        chk(0, "rst_in_rdy", 32'(in_rdy[0]), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk(0, "rst_no_stale", 32'(out_vld[0]), 0);
        end
        out_rdy[0] = 0;

        // cfg1: continuous streaming, one transfer per cycle with occupancy 1
        step(); in_vld[1] = 1; out_rdy[1] = 1; in_pd[1] = 15'd100;
        for (int i = 1; i <= 20; i++) begin
            step(); in_pd[1] = 15'(100 + i);
            @(negedge clk);
            chk(1, "stream_occ", 32'(occ[1]), 1);
            chk(1, "stream_pd", 32'(out_pd[1]), 32'(100 + i - 1));
        end
        in_vld[1] = 0;
        step(); out_rdy[1] = 0;

        // cfg1: flush at occupancy 3 beats a simultaneous push
        step(); in_vld[1] = 1; in_pd[1] = 15'h0001;
        step(); in_pd[1] = 15'h0002;
        step(); in_pd[1] = 15'h0003;
        step(); flush[1] = 1; in_pd[1] = 15'h0077;
        @(negedge clk);
        chk(1, "preflush_occ", 32'(occ[1]), 3);
        step(); flush[1] = 0; in_pd[1] = 15'h0055;
        @(negedge clk);
        chk(1, "flush_occ", 32'(occ[1]), 0);
        chk(1, "flush_out_vld", 32'(out_vld[1]), 0);
        step(); in_vld[1] = 0; out_rdy[1] = 1;
        @(negedge clk);
        chk(1, "postflush_pd", 32'(out_pd[1]), 32'h55);
        step(); out_rdy[1] = 0;

        // cfg2: single entry with bypass ready pops and pushes in the same cycle
        step(); in_vld[2] = 1; in_pd[2] = 15'h1234;
        step(); in_pd[2] = 15'h7FFF; out_rdy[2] = 1;
        @(negedge clk);
        chk(2, "byp_full_in_rdy", 32'(in_rdy[2]), 1);
        chk(2, "byp_head", 32'(out_pd[2]), 32'h1234);
        step(); in_vld[2] = 0; out_rdy[2] = 0;
        @(negedge clk);
        chk(2, "byp_swap_pd", 32'(out_pd[2]), 32'h7FFF);
        chk(2, "byp_swap_occ", 32'(occ[2]), 1);
        chk(2, "byp_blocked", 32'(in_rdy[2]), 0);
        step(); out_rdy[2] = 1;
        step(); out_rdy[2] = 0;

        // all configurations: random traffic with sparse flush and reset
        for (int i = 0; i < 900; i++) begin
            int vd;
            vd = 1 + (i / 150) % 3;
            step();
            for (int k = 0; k < 3; k++) begin
                rst[k]     = $urandom_range(0, 149) == 0;
                flush[k]   = $urandom_range(0, 39) == 0;
                in_vld[k]  = $urandom_range(0, 3) < vd;
                out_rdy[k] = $urandom_range(0, 3) >= vd - 1;
                in_pd[k]   = 15'($urandom);
            end
        end
        step(); rst = '0; flush = '0; in_vld = '0; out_rdy = '1;
        repeat (6) step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk(k, "final_drain", 32'(out_vld[k]), 0);
        out_rdy = '0;

`ifdef NVDLA_CDP_PIPE_STALL_CNT_EN
        step(); in_vld[0] = 1; in_pd[0] = 15'h01EE;
        step(); in_vld[0] = 0;
        repeat (70000) step();
        @(negedge clk);
        chk(0, "stall_sat", 32'(stall_cnt[0]), 32'hFFFF);
        step(); flush[0] = 1;
        step(); flush[0] = 0;
        @(negedge clk);
        chk(0, "stall_flush", 32'(stall_cnt[0]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
